// File: rtl/mul_sequencer_if.sv
// Execute-stage multiply bus: operands and control from the core, stall/result back.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             AccE;
    logic             AbortE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] SrcCE;
    logic             StallMulE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] MulResultE;
    logic [1:0]       MulFlagsE;

    modport master (
        output StartE, AccE, AbortE, SrcAE, SrcBE, SrcCE,
        input  StallMulE, BusyE, DoneE, MulResultE, MulFlagsE
    );

    modport slave (
        input  StartE, AccE, AbortE, SrcAE, SrcBE, SrcCE,
        output StallMulE, BusyE, DoneE, MulResultE, MulFlagsE
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply sequencer for MUL/MLA in Execute; stalls F/D/E while running.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a multiply; operands latched on accepted start
//   RUN    | one shift-add step per cycle, exits early once mplier drains
//   DONE   | result and flags valid for one cycle, instruction advances
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mul_sequencer_if.slave  mul_if
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    assign accept = (state_q == S_IDLE) && mul_if.StartE && !mul_if.AbortE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = mul_if.SrcAE;
                    mplier_d = mul_if.SrcBE;
                    acc_d    = mul_if.AccE ? mul_if.SrcCE : '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Remaining multiplier bits all zero means no further adds can change acc.
                if ((mplier_d == '0) || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush freezes the datapath so the last visible result is left untouched.
        if (mul_if.AbortE) begin
            state_d  = S_IDLE;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            acc_d    = acc_q;
            cnt_d    = cnt_q;
        end
    end

    assign mul_if.StallMulE  = accept || ((state_q == S_RUN) && !mul_if.AbortE);
    assign mul_if.BusyE      = (state_q == S_RUN);
    assign mul_if.DoneE      = (state_q == S_DONE) && !mul_if.AbortE;
    assign mul_if.MulResultE = acc_q;
    assign mul_if.MulFlagsE  = {acc_q[WIDTH-1], (acc_q == '0)};
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: cycle-level reference model plus directed vectors.
module tb_mul_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    mul_sequencer_if #(.WIDTH(32)) bus ();

    mul_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .mul_if (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [31:0] b);
        int p = -1;
        for (int i = 0; i < 32; i++) if (b[i]) p = i;
        return (p < 0) ? 1 : p + 1;
    endfunction

    // Reference model: phase 0 idle, 1 multiplying (m_left cycles to go), 2 result cycle.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
        end else if (bus.AbortE) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (bus.StartE) begin
                    m_phase <= 1;
                    m_left  <= run_len(bus.SrcBE);
                    m_res   <= bus.SrcAE * bus.SrcBE + (bus.AccE ? bus.SrcCE : 32'd0);
                end
                1: if (m_left == 1) m_phase <= 2; else m_left <= m_left - 1;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_stall, exp_done;
            exp_stall = !bus.AbortE && ((m_phase == 0 && bus.StartE) || m_phase == 1);
            exp_done  = (m_phase == 2) && !bus.AbortE;
            chk("cyc_stall", {31'd0, bus.StallMulE}, {31'd0, exp_stall});
            chk("cyc_busy",  {31'd0, bus.BusyE},     {31'd0, (m_phase == 1)});
            chk("cyc_done",  {31'd0, bus.DoneE},     {31'd0, exp_done});
            if (exp_done) begin
                chk("cyc_result", bus.MulResultE, m_res);
                chk("cyc_flags",  {30'd0, bus.MulFlagsE}, {30'd0, m_res[31], (m_res == 32'd0)});
            end
        end
    end

    task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic acc, input logic [31:0] exp_res,
                          input logic [1:0] exp_fl, input int exp_stall);
        int          stalls = 0;
        bit          got = 1'b0;
        logic [31:0] r = '0;
        logic [1:0]  f = '0;
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.AccE = acc;
        bus.SrcAE = a; bus.SrcBE = b; bus.SrcCE = c;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.StallMulE) stalls++;
            if (bus.DoneE) begin
                got = 1'b1; r = bus.MulResultE; f = bus.MulFlagsE;
            end
            @(posedge clk); #1;
            // Scrambled operands after capture must not disturb the result.
            bus.SrcAE = $urandom; bus.SrcBE = $urandom; bus.SrcCE = $urandom;
        end
        bus.StartE = 1'b0; bus.AccE = 1'b0;
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_result"}, r, exp_res);
        chk({name, "_flags"}, {30'd0, f}, {30'd0, exp_fl});
        chk({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        int dones;
        bus.StartE = 1'b0; bus.AccE = 1'b0; bus.AbortE = 1'b0;
        bus.SrcAE = '0; bus.SrcBE = '0; bus.SrcCE = '0;
        #22;
        chk("rst_stall",  {31'd0, bus.StallMulE}, 32'd0);
        chk("rst_busy",   {31'd0, bus.BusyE},     32'd0);
        chk("rst_done",   {31'd0, bus.DoneE},     32'd0);
        chk("rst_result", bus.MulResultE,         32'd0);
        chk("rst_flags",  {30'd0, bus.MulFlagsE}, 32'd1);
        reset = 1'b1;
        chk_en = 1'b1;

        do_mul("mul_3x5",     32'd3,          32'd5,          32'd0, 1'b0, 32'd15,         2'b00, 4);
        do_mul("mla_7x0p9",   32'd7,          32'd0,          32'd9, 1'b1, 32'd9,          2'b00, 2);
        do_mul("mul_ffxff",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 1'b0, 32'd1,          2'b00, 33);
        do_mul("mul_msb",     32'h8000_0000,  32'd1,          32'd0, 1'b0, 32'h8000_0000,  2'b10, 2);
        do_mul("mul_ovf",     32'h0001_0000,  32'h0001_0000,  32'd0, 1'b0, 32'd0,          2'b01, 18);
        do_mul("mla_wrap",    32'hFFFF_FFFF,  32'd2,          32'd3, 1'b1, 32'd1,          2'b00, 3);
        do_mul("mla_zero",    32'd5,          32'd6,  32'hFFFF_FFE2, 1'b1, 32'd0,          2'b01, 4);

        // Abort on the second RUN cycle of 3 x 0xFF.
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.SrcAE = 32'd3; bus.SrcBE = 32'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.AbortE = 1'b1; bus.StartE = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'd0, bus.StallMulE}, 32'd0);
        @(posedge clk); #1;
        bus.AbortE = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.DoneE) dones++;
        end
        chk("abort_no_done", dones, 0);
        do_mul("after_abort", 32'd2, 32'd2, 32'd0, 1'b0, 32'd4, 2'b00, 3);

        // Asynchronous reset in the middle of a long multiply.
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.SrcAE = 32'd3; bus.SrcBE = 32'hFF;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0; bus.StartE = 1'b0;
        #1;
        chk("midrst_stall",  {31'd0, bus.StallMulE}, 32'd0);
        chk("midrst_busy",   {31'd0, bus.BusyE},     32'd0);
        chk("midrst_done",   {31'd0, bus.DoneE},     32'd0);
        chk("midrst_result", bus.MulResultE,         32'd0);
        chk("midrst_flags",  {30'd0, bus.MulFlagsE}, 32'd1);
        @(negedge clk); #2;
        reset = 1'b1;
        do_mul("after_rst", 32'd11, 32'd13, 32'd0, 1'b0, 32'd143, 2'b00, 5);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
